lfu_tracker: RTL
================

# lfu_tracker

Parametrised least-frequently-used replacement tracker for an N-entry buffer pool. It is the successor to the fixed 4-buffer, 2-bit LFU finder. It keeps one saturating reference counter per buffer and continuously reports the unlocked buffer with the lowest count as the replacement victim. It adds counter aging, per-buffer lock masking and an explicit reference-valid qualifier. It sits beside the buffer manager, which issues reference and replacement requests.

## Interface
- BUF_BIT, default 2: buffer index width; NBUF = 2**BUF_BIT buffers.
- CNT_W, default 2: reference counter width; CNT_MAX = 2**CNT_W-1.
- AGE_EN, default 1: 1 = age all counters on overflow; 0 = legacy saturate-and-flag mode.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ref_vld  in  1  qualifies ref_buf_req for this cycle.
- ref_buf_req  in  BUF_BIT  index of the buffer being referenced.
- new_buf_req  in  1  victim buf_num_replc is being refilled; its counter is cleared.
- lock  in  NBUF  bit i = 1 excludes buffer i from victim selection.
- buf_num_replc  out  BUF_BIT  registered victim index.
- replc_vld  out  1  registered; 1 when at least one buffer is unlocked.
- max_flg  out  1  registered; see Operation.

## Operation
- State: cnt[0..NBUF-1], CNT_W bits each.
- Reset, rst_n low at an edge: all cnt = 0, buf_num_replc = 0, replc_vld = 1, max_flg = 0. Reset overrides every other input.
- Reference (ref_vld = 1, r = ref_buf_req):
  - cnt[r] < CNT_MAX: cnt[r] += 1.
  - cnt[r] == CNT_MAX, AGE_EN = 1: aging event. Every cnt[i] >>= 1 in the same edge, then cnt[r] = (CNT_MAX>>1)+1. max_flg is high for exactly one cycle.
  - cnt[r] == CNT_MAX, AGE_EN = 0: cnt[r] holds. max_flg is set at the edge where any counter first reaches CNT_MAX and stays high (sticky) until reset.
- Replacement (new_buf_req = 1): v = the current registered buf_num_replc, cnt[v] = 0.
  - Ignored when replc_vld = 0.
  - Ignored when lock[v] = 1 at that cycle.
- Simultaneous reference and replacement:
  - r == v: cnt[v] = 1. The new content counts as referenced once.
  - r != v: both updates apply. If the reference triggers aging, the halving applies to all counters except v, which becomes 0.
- Victim selection: argmin of cnt over buffers with lock = 0. Ties resolve to the lowest index.
- All locked: replc_vld = 0 and buf_num_replc holds its previous value.
- ref_vld = 0: ref_buf_req is don't-care, including X.

## Timing
- Counters update at edge k.
- buf_num_replc and replc_vld are registered from the counters and lock as they stand after edge k. They become visible after edge k+1, so they trail the counters by one cycle.
- A new_buf_req issued in the cycle right after a counter change uses the stale victim. This is intended; the buffer manager tolerates it.
- lock affects the outputs one cycle later. It affects the new_buf_req ignore check in the same cycle.
- AGE_EN = 1: max_flg rises at the aging edge and falls at the next edge.
- No back-pressure. One reference and one replacement can be accepted every cycle.

## Structure
- Package lfu_pkg holds:
  - function nbuf(BUF_BIT)
  - function cnt_max(CNT_W)
  - localparam defaults, shared with the buffer manager.
- Sub-module lfu_min_tree: combinational, parametrised by BUF_BIT and CNT_W.
  - Inputs: flattened counters and the lock mask.
  - Outputs: min index and any_unlocked.
  - Built as a log2(NBUF)-level compare tree with lowest-index tie-break.
- Top level holds the counter update logic, aging and the output registers.

## Test plan
All scenarios use BUF_BIT = 2, CNT_W = 2 unless stated.
- Reset: hold rst_n low for 2 cycles, then release. Expect all cnt = 0, buf_num_replc = 0, replc_vld = 1, max_flg = 0. Reassert rst_n mid-sequence and expect the same values after one edge.
- Ranking: refs buf0 ×3, buf1 ×2, buf2 ×1, buf3 ×2. Expect cnt = {3,2,1,2} and buf_num_replc = 2 one cycle after the last ref. Pulse new_buf_req: expect cnt2 = 0 and buf_num_replc stays 2.
- Aging (AGE_EN = 1): cnt = {3,2,1,0}, then ref buf0. Expect cnt = {2,1,0,0}, a max_flg pulse of exactly one cycle, and buf_num_replc = 2.
- Legacy (AGE_EN = 0): ref buf1 ×5. Expect cnt1 = 3 held and max_flg high from the 3rd ref until rst_n low.
- Lock: all cnt = 0, lock = 4'b0001. Expect buf_num_replc = 1. Set lock = 4'b1111: expect replc_vld = 0 next cycle, and new_buf_req leaves all counters unchanged.
- Collision: buf_num_replc = 3, ref buf3 with new_buf_req in the same cycle: expect cnt3 = 1. Ref buf0 with new_buf_req (victim 3): expect cnt0 +1 and cnt3 = 0.

Source files
------------

// File: rtl/lfu_pkg.sv
// Shared definitions for the LFU replacement tracker and the buffer manager
// that drives it: default geometry and helpers to derive pool size and
// counter ceiling from the parameter widths.
package lfu_pkg;

  localparam int BUF_BIT_DEF = 2;
  localparam int CNT_W_DEF   = 2;
  localparam bit AGE_EN_DEF  = 1'b1;

  // Number of buffers addressed by a buf_bit-wide index.
  function automatic int nbuf(input int buf_bit);
    return 1 << buf_bit;
  endfunction

  // Saturation value of a cnt_w-wide reference counter.
  function automatic int cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/lfu_tracker_if.sv
// Bus between the buffer manager (master) and the LFU tracker (slave).
//
// Handshake: there is no back-pressure. ref_vld qualifies ref_buf_req in the
// cycle it is high and is always accepted; new_buf_req is likewise accepted
// every cycle (the tracker itself ignores it when no victim is valid or the
// victim is locked). buf_num_replc / replc_vld / max_flg are registered
// status outputs; replc_vld plays the role of "victim valid".
interface lfu_tracker_if import lfu_pkg::*; #(
  parameter int BUF_BIT = BUF_BIT_DEF
);
  localparam int NBUF = nbuf(BUF_BIT);

  logic               ref_vld;
  logic [BUF_BIT-1:0] ref_buf_req;
  logic               new_buf_req;
  logic [NBUF-1:0]    lock;
  logic [BUF_BIT-1:0] buf_num_replc;
  logic               replc_vld;
  logic               max_flg;

  modport master (
    output ref_vld, ref_buf_req, new_buf_req, lock,
    input  buf_num_replc, replc_vld, max_flg
  );

  modport slave (
    input  ref_vld, ref_buf_req, new_buf_req, lock,
    output buf_num_replc, replc_vld, max_flg
  );
endinterface

// File: rtl/lfu_min_tree.sv
// Combinational argmin over the unlocked reference counters. Organised as a
// heap-ordered binary compare tree: leaves sit at nodes NBUF-1..2*NBUF-2 in
// buffer order, so a left child always covers lower indices than its sibling
// and preferring the left side on equal counts gives lowest-index tie-break.
module lfu_min_tree import lfu_pkg::*; #(
  parameter int BUF_BIT = BUF_BIT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic [nbuf(BUF_BIT)*CNT_W-1:0] cnt_flat,
  input  logic [nbuf(BUF_BIT)-1:0]       lock,
  output logic [BUF_BIT-1:0]             min_idx,
  output logic                           any_unlocked
);
  localparam int NBUF  = nbuf(BUF_BIT);
  localparam int NODES = 2 * NBUF - 1;

  logic [CNT_W-1:0]   node_val [NODES];
  logic [BUF_BIT-1:0] node_idx [NODES];
  logic               node_ok  [NODES];

  // Leaves: one per buffer, eligible only when unlocked.
  for (genvar i = 0; i < NBUF; i++) begin : g_leaf
    assign node_val[NBUF-1+i] = cnt_flat[i*CNT_W +: CNT_W];
    assign node_idx[NBUF-1+i] = BUF_BIT'(i);
    assign node_ok[NBUF-1+i]  = ~lock[i];
  end

  // Internal nodes: keep the smaller eligible child, left wins ties.
  for (genvar j = 0; j < NBUF - 1; j++) begin : g_node
    logic take_l;
    assign take_l = node_ok[2*j+1] &&
                    (!node_ok[2*j+2] || (node_val[2*j+1] <= node_val[2*j+2]));
    assign node_val[j] = take_l ? node_val[2*j+1] : node_val[2*j+2];
    assign node_idx[j] = take_l ? node_idx[2*j+1] : node_idx[2*j+2];
    assign node_ok[j]  = node_ok[2*j+1] | node_ok[2*j+2];
  end

  assign min_idx      = node_idx[0];
  assign any_unlocked = node_ok[0];
endmodule

// File: rtl/lfu_tracker.sv
// LFU replacement tracker: one saturating reference counter per buffer,
// optional aging (halve everything when a saturated counter is referenced
// again), and a registered victim = lowest-count unlocked buffer. The victim
// is computed from the registered counters, so it trails them by one cycle.
module lfu_tracker import lfu_pkg::*; #(
  parameter int BUF_BIT = BUF_BIT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter bit AGE_EN  = AGE_EN_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  lfu_tracker_if.slave bus
);
  localparam int               NBUF     = nbuf(BUF_BIT);
  localparam logic [CNT_W-1:0] CMAX     = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] AGED_REF = (CMAX >> 1) + 1'b1;

  logic [CNT_W-1:0]      cnt     [NBUF];
  logic [CNT_W-1:0]      cnt_nxt [NBUF];
  logic [NBUF*CNT_W-1:0] cnt_flat;
  logic [BUF_BIT-1:0]    ref_idx;
  logic [BUF_BIT-1:0]    min_idx;
  logic                  any_unlocked;
  logic                  ref_at_max;
  logic                  aging;
  logic                  rep_hit;
  logic                  hit_max;

  lfu_min_tree #(.BUF_BIT(BUF_BIT), .CNT_W(CNT_W)) u_min_tree (
    .cnt_flat     (cnt_flat),
    .lock         (bus.lock),
    .min_idx      (min_idx),
    .any_unlocked (any_unlocked)
  );

  // Next counter values: aging halves first, then the reference, then a
  // replacement clear of the victim (which wins over halving; a same-buffer
  // reference leaves the refilled buffer at one reference).
  always_comb begin
    ref_idx    = bus.ref_vld ? bus.ref_buf_req : '0;
    ref_at_max = bus.ref_vld && (cnt[ref_idx] == CMAX);
    aging      = AGE_EN && ref_at_max;
    rep_hit    = bus.new_buf_req && bus.replc_vld && !bus.lock[bus.buf_num_replc];
    hit_max    = 1'b0;
    cnt_flat   = '0;
    for (int i = 0; i < NBUF; i++) begin
      cnt_nxt[i] = aging ? (cnt[i] >> 1) : cnt[i];
      if (bus.ref_vld && (ref_idx == BUF_BIT'(i))) begin
        if (!ref_at_max)
          cnt_nxt[i] = cnt[i] + 1'b1;
        else if (aging)
          cnt_nxt[i] = AGED_REF;
        else
          cnt_nxt[i] = cnt[i];
      end
      if (rep_hit && (bus.buf_num_replc == BUF_BIT'(i)))
        cnt_nxt[i] = (bus.ref_vld && (ref_idx == BUF_BIT'(i))) ? CNT_W'(1) : '0;
      hit_max = hit_max | (cnt_nxt[i] == CMAX);
      cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NBUF; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBUF; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Registered victim, victim-valid and overflow flag; the victim index holds
  // while every buffer is locked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.buf_num_replc <= '0;
      bus.replc_vld     <= 1'b1;
      bus.max_flg       <= 1'b0;
    end else begin
      if (any_unlocked) bus.buf_num_replc <= min_idx;
      bus.replc_vld <= any_unlocked;
      bus.max_flg   <= AGE_EN ? aging : (bus.max_flg | hit_max);
    end
  end
endmodule
